// File: rtl/asyn_fifo_rd_packer.sv
// Read-side consumer of asyn_fifo in the rclk domain. Pops RATIO consecutive
// entries and packs them into one OUT_WIDTH word on a valid/ready stream.
// Partial words are never emitted.
//
// Ports:
//   rclk      - read-domain clock
//   rrstn     - asynchronous active-low reset (shared with the FIFO read side)
//   rempty    - FIFO empty flag
//   rinc      - FIFO read request (never asserted while rempty=1)
//   rdata     - FIFO read data, valid one cycle after an accepted read
//   out_valid - packed word valid
//   out_ready - downstream accepts the word
//   out_data  - packed word; lane 0 (first entry read) in [WIDTH-1:0]
module asyn_fifo_rd_packer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic                   rclk,
    input  logic                   rrstn,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic [WIDTH-1:0]       rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data
);

    localparam int unsigned OUT_WIDTH = WIDTH * RATIO;
    localparam int unsigned CW        = $clog2(RATIO + 1);

    localparam logic [CW-1:0] RatioC = CW'(RATIO);
    localparam logic [CW-1:0] LastC  = CW'(RATIO - 1);

    typedef enum logic [1:0] {StFill, StDrain, StPresent} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          issued_q, issued_d;
    logic [CW-1:0]          filled_q, filled_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;

    logic accept;
    logic load;

    assign rinc   = (state_q == StFill) & ~rempty & (issued_q < RatioC);
    assign accept = rinc & ~rempty;
    // The output slot is free when empty or being drained this cycle.
    assign load   = (state_q == StPresent) & (~out_valid_q | out_ready);

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        filled_d    = filled_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_pend_d   = accept;

        if (accept) begin
            issued_d = issued_q + CW'(1);
        end

        // RAM read latency is one cycle: capture the entry requested last cycle.
        if (rd_pend_q) begin
            for (int unsigned l = 0; l < RATIO; l++) begin
                if (filled_q == CW'(l)) begin
                    acc_d[l*WIDTH +: WIDTH] = rdata;
                end
            end
            filled_d = filled_q + CW'(1);
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StFill: begin
                if (accept && (issued_q == LastC)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Move on in the same cycle the last lane is captured.
                if (filled_d == RatioC) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (load) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    issued_d    = '0;
                    filled_d    = '0;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state_q     <= StFill;
            issued_q    <= '0;
            filled_q    <= '0;
            rd_pend_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            filled_q    <= filled_d;
            rd_pend_q   <= rd_pend_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
